uart_frame_loader: RTL and testbench
====================================

# uart_frame_loader

Byte-stream frame parser and matrix write sequencer that sits between the UART receiver and the matrix storage of the calculator. It consumes single-cycle byte strobes, validates a framed matrix transfer (header, dimensions, elements, checksum) and issues row-major element writes to storage. It reports frame completion or a classified error, so the top-level controller can accept or discard the loaded matrix.

## Interface
- MAX_DIM, 5, largest legal row/column count; legal range 1..MAX_DIM
- ADDR_W, 5, element address width; must satisfy 2^ADDR_W ≥ MAX_DIM*MAX_DIM
- HEADER, 8'hAA, frame start byte
- TIMEOUT_CYCLES, 10_000_000, maximum idle clocks between bytes inside a frame (100 ms at 100 MHz)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  single-cycle byte strobe
- wr_en  out  1  element write strobe, one cycle per element
- wr_addr  out  ADDR_W  row-major element index, row*cols+col
- wr_data  out  8  element value
- mat_rows  out  3  row count of last successful frame
- mat_cols  out  3  column count of last successful frame
- busy  out  1  high in every state except IDLE
- frame_done  out  1  single-cycle pulse on successful frame
- frame_err  out  1  single-cycle pulse on aborted frame
- err_code  out  2  cause of last error: 1 bad dimension, 2 checksum mismatch, 3 timeout; holds until next error; 0 after reset

## Operation
- Frame format: HEADER, R, C, R*C element bytes, CSUM.
- CSUM = (R + C + sum of elements) mod 256.
- FSM states: IDLE, ROWS, COLS, DATA, CSUM.
- IDLE: bytes ≠ HEADER are ignored; HEADER → ROWS, and the running sum and element index clear.
- ROWS: byte latched as R; R==0 or R>MAX_DIM → error 1, IDLE; otherwise → COLS.
- COLS: byte latched as C with the same legality check; otherwise → DATA. Expected count N = R*C, computed with a 5-bit product.
- DATA: each byte is written at index idx (0..N-1), added to the running sum (8-bit wrap), and idx increments. The byte with idx==N-1 → CSUM.
- CSUM: byte == sum → frame_done, mat_rows/mat_cols ← R/C. Otherwise → error 2, and mat_rows/mat_cols are unchanged. Either outcome → IDLE.
- Elements are written through as they arrive. On error, storage contents are undefined, and the consumer must honour frame_err.
- Timeout: the counter clears on every rx_done and in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 without a byte → error 3, IDLE.
- A HEADER byte received mid-frame is treated as ordinary data; no resynchronisation.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, mat_rows=0, mat_cols=0, busy=0, frame_done=0, frame_err=0, err_code=0, state IDLE.
- All outputs are registered.
- wr_en, wr_addr and wr_data are valid in the cycle after the corresponding rx_done.
- frame_done/frame_err assert one cycle after the CSUM or offending byte's rx_done. For timeout, they assert the cycle after the counter reaches the terminal value.
- mat_rows/mat_cols update in the same cycle as frame_done.
- frame_done and frame_err are never high together.
- rx_done in the same cycle as timeout terminal count: the byte wins, the counter clears, and no error is raised.
- rx_done on consecutive cycles is accepted; throughput is 1 byte/cycle.
- Reset mid-frame: immediate return to IDLE with the reset values; no partial pulses.

## Test plan
- Valid 2×3 frame AA 02 03 01 02 03 04 05 06 1A → six wr_en pulses at addr 0..5 with data 01..06, frame_done=1 once, mat_rows=2, mat_cols=3, busy falls after CSUM.
- Same frame with CSUM 1B → six writes, frame_err pulse, err_code=2, mat_rows/mat_cols retain prior values.
- AA 06 → frame_err and err_code=1 after byte 2, no writes; then AA 00 → err_code=1 again.
- AA 01 01, then silence for TIMEOUT_CYCLES (bench overrides to 50) → frame_err, err_code=3 after 50 idle clocks, busy=0. A byte at cycle 49 of a second run → no error.
- Garbage 55 00 FF, then valid 1×1 frame AA 01 01 AA AC → single write addr 0 data AA, frame_done, mat 1×1.
- rst_n low during DATA of a 5×5 frame → all outputs at reset values. The following valid frame loads normally.

Source files
------------

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - framed matrix byte-stream parser and row-major element write sequencer
module uart_frame_loader #(
    parameter int         MAX_DIM        = 5,
    parameter int         ADDR_W         = 5,
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_done_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [2:0]        mat_rows_o,
    output logic [2:0]        mat_cols_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic [1:0]        err_code_o
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_DIM  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROWS,
        S_COLS,
        S_DATA,
        S_CSUM
    } state_t;

    state_t            state_q;
    logic [2:0]        rows_q;
    logic [2:0]        cols_q;
    logic [7:0]        sum_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] last_q;
    logic [CNT_W-1:0]  tmo_q;

    logic              dim_ok_d;
    logic              timeout_d;
    logic [ADDR_W-1:0] count_d;

    always_comb begin
        dim_ok_d  = (rx_data_i != 8'd0) && (rx_data_i <= 8'(MAX_DIM));
        // An arriving byte always beats the terminal count.
        timeout_d = (state_q != S_IDLE) && (tmo_q == TMO_LAST) && !rx_done_i;
        count_d   = ADDR_W'(rows_q) * ADDR_W'(rx_data_i[2:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rows_q       <= 3'd0;
            cols_q       <= 3'd0;
            sum_q        <= 8'd0;
            idx_q        <= '0;
            last_q       <= '0;
            tmo_q        <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= 8'd0;
            mat_rows_o   <= 3'd0;
            mat_cols_o   <= 3'd0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            err_code_o   <= 2'd0;
        end else begin
            wr_en_o      <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;

            if (rx_done_i || state_q == S_IDLE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end

            if (timeout_d) begin
                state_q     <= S_IDLE;
                busy_o      <= 1'b0;
                frame_err_o <= 1'b1;
                err_code_o  <= ERR_TMO;
            end else if (rx_done_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_data_i == HEADER) begin
                            state_q <= S_ROWS;
                            busy_o  <= 1'b1;
                            sum_q   <= 8'd0;
                            idx_q   <= '0;
                        end
                    end
                    S_ROWS: begin
                        if (!dim_ok_d) begin
                            state_q     <= S_IDLE;
                            busy_o      <= 1'b0;
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_DIM;
                        end else begin
                            state_q <= S_COLS;
                            rows_q  <= rx_data_i[2:0];
                            sum_q   <= sum_q + rx_data_i;
                        end
                    end
                    S_COLS: begin
                        if (!dim_ok_d) begin
                            state_q     <= S_IDLE;
                            busy_o      <= 1'b0;
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_DIM;
                        end else begin
                            state_q <= S_DATA;
                            cols_q  <= rx_data_i[2:0];
                            sum_q   <= sum_q + rx_data_i;
                            last_q  <= count_d - ADDR_W'(1);
                        end
                    end
                    S_DATA: begin
                        // Elements go straight to storage; an error later leaves them stale.
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= idx_q;
                        wr_data_o <= rx_data_i;
                        sum_q     <= sum_q + rx_data_i;
                        idx_q     <= idx_q + ADDR_W'(1);
                        if (idx_q == last_q) begin
                            state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        state_q <= S_IDLE;
                        busy_o  <= 1'b0;
                        if (rx_data_i == sum_q) begin
                            frame_done_o <= 1'b1;
                            mat_rows_o   <= rows_q;
                            mat_cols_o   <= cols_q;
                        end else begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_CSUM;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed self-checking bench for uart_frame_loader
`timescale 1ns/1ps
module tb_uart_frame_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] mat_rows;
    logic [2:0] mat_cols;
    logic       busy;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    int wa_q[$];
    int wd_q[$];
    int done_cnt;
    int err_cnt;

    uart_frame_loader #(
        .MAX_DIM       (5),
        .ADDR_W        (5),
        .HEADER        (8'hAA),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data_i   (rx_data),
        .rx_done_i   (rx_done),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .mat_rows_o  (mat_rows),
        .mat_cols_o  (mat_cols),
        .busy_o      (busy),
        .frame_done_o(frame_done),
        .frame_err_o (frame_err),
        .err_code_o  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (wr_en) begin
                wa_q.push_back(int'(wr_addr));
                wd_q.push_back(int'(wr_data));
            end
            if (frame_done) done_cnt = done_cnt + 1;
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic check_writes(input string tag, input int n, input int base);
        check({tag, "_wr_count"}, wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check({tag, "_wr_addr"}, wa_q[i], i);
            check({tag, "_wr_data"}, wd_q[i], base + i);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        clear_log();
        repeat (3) @(negedge clk);

        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_mat", {mat_rows, mat_cols}, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_done, frame_err}, 0);
        check("rst_err_code", err_code, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Valid 2x3 frame: 2+3+1+2+3+4+5+6 = 26 = 0x1A
        clear_log();
        send_byte(8'hAA);
        check("v23_busy_hdr", busy, 1);
        send_byte(8'h02);
        send_byte(8'h03);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        check("v23_busy_before_csum", busy, 1);
        send_byte(8'h1A);
        check("v23_done", frame_done, 1);
        check("v23_err", frame_err, 0);
        check("v23_rows", mat_rows, 2);
        check("v23_cols", mat_cols, 3);
        check("v23_busy_after", busy, 0);
        @(negedge clk);
        check("v23_done_once", done_cnt, 1);
        check_writes("v23", 6, 1);

        // Same frame, wrong checksum
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h03);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        send_byte(8'h1B);
        check("bad_csum_err", frame_err, 1);
        check("bad_csum_done", frame_done, 0);
        check("bad_csum_code", err_code, 2);
        check("bad_csum_rows", mat_rows, 2);
        check("bad_csum_cols", mat_cols, 3);
        @(negedge clk);
        check("bad_csum_done_cnt", done_cnt, 0);
        check_writes("bad_csum", 6, 1);

        // Illegal dimensions
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h06);
        check("dim6_err", frame_err, 1);
        check("dim6_code", err_code, 1);
        check("dim6_busy", busy, 0);
        send_byte(8'hAA);
        send_byte(8'h00);
        check("dim0_err", frame_err, 1);
        check("dim0_code", err_code, 1);
        @(negedge clk);
        check("dim_err_cnt", err_cnt, 2);
        check("dim_writes", wa_q.size(), 0);

        // Timeout: 50 idle clocks after the last byte
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (49) @(negedge clk);
        check("tmo_not_yet", frame_err, 0);
        check("tmo_busy_pre", busy, 1);
        @(negedge clk);
        check("tmo_err", frame_err, 1);
        check("tmo_code", err_code, 3);
        check("tmo_busy", busy, 0);

        // Byte lands exactly on the terminal count: no timeout
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (49) @(negedge clk);
        send_byte(8'h05);
        check("tmo_edge_err", frame_err, 0);
        check("tmo_edge_wr", {wr_en, wr_data}, {1'b1, 8'h05});
        send_byte(8'h07);
        check("tmo_edge_done", frame_done, 1);
        @(negedge clk);
        check("tmo_edge_err_cnt", err_cnt, 0);

        // Garbage then a 1x1 frame whose element equals HEADER
        clear_log();
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_busy", busy, 0);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hAC);
        check("one_done", frame_done, 1);
        check("one_rows", mat_rows, 1);
        check("one_cols", mat_cols, 1);
        @(negedge clk);
        check_writes("one", 1, 8'hAA);
        check("one_err_cnt", err_cnt, 0);

        // Reset in the middle of a 5x5 frame
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h05);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_mat", {mat_rows, mat_cols}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_code", err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5x5 after reset: 5+5+325 = 335 -> 0x4F
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h05);
        for (int i = 1; i <= 25; i++) send_byte(8'(i));
        send_byte(8'h4F);
        check("v55_done", frame_done, 1);
        check("v55_rows", mat_rows, 5);
        check("v55_cols", mat_cols, 5);
        @(negedge clk);
        check_writes("v55", 25, 1);
        check("v55_err_cnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
